// File: rtl/sram_mem_controller.sv
// sram_mem_controller: MEM-stage responder doing 32-bit loads/stores as two 16-bit SRAM transactions
module sram_mem_controller #(
    parameter int ADDR_BASE   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q;
    logic [16:0]   word_q;
    logic [31:0]   wdata_q, rdata_q;
    logic          req, last, busy, drive;
    assign req   = mem_read | mem_write;
    assign last  = cnt_q == CW'(WAIT_CYCLES - 1);
    assign busy  = state_q == LO || state_q == HI;
    assign drive = busy & wr_q;
    // Next state: each half is held for WAIT_CYCLES cycles, then one DONE cycle releases the pipeline
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = req ? LO : IDLE;
                cnt_d   = '0;
            end
            LO, HI: begin
                cnt_d   = last ? '0 : cnt_q + 1'b1;
                state_d = !last ? state_q : (state_q == LO ? HI : DONE);
            end
            default: state_d = IDLE;
        endcase
    end
    // State, latched request and load capture; the request is snapshotted so the pipeline may drop it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req) begin
                wr_q    <= mem_write;
                word_q  <= 17'((address - 32'(ADDR_BASE)) >> 2);
                wdata_q <= write_data;
            end
            if (busy && last && !wr_q) begin
                if (state_q == HI) rdata_q[31:16] <= SRAM_DQ;
                else rdata_q[15:0] <= SRAM_DQ;
            end
        end
    end
    assign SRAM_ADDR = {word_q, state_q == HI};
    assign SRAM_WE_N = ~drive;
    assign SRAM_DQ   = drive ? (state_q == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = rdata_q;
    assign ready     = state_q == DONE || (state_q == IDLE && !req);
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb_sram_mem_controller: table-driven accesses against an SRAM model with a per-cycle scoreboard
module tb_sram_mem_controller;
    localparam int W = 2;
    logic        clk, rst, mem_read, mem_write, ready;
    logic [31:0] address, write_data, read_data;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N;
    wire  [15:0] SRAM_DQ;
    logic        tb_init;
    logic [15:0] mem [0:255];
    int          wc;
    logic [17:0] pa;
    int          n_cmp = 0, n_bad = 0;

    sram_mem_controller #(.ADDR_BASE(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
    );

    always #5 clk = ~clk;

    // SRAM model: drives data whenever not written; a write commits only after a full W-cycle pulse
    assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR[7:0]] : 16'hzzzz;
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[4] <= 16'h1234;
            mem[5] <= 16'hABCD;
            wc <= 0;
            pa <= '0;
        end else if (!SRAM_WE_N) begin
            wc <= (SRAM_ADDR == pa) ? wc + 1 : 1;
            pa <= SRAM_ADDR;
            if (((SRAM_ADDR == pa) ? wc + 1 : 1) == W) mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
        end else begin
            wc <= 0;
        end
    end

    typedef struct {
        string       name;
        logic        rd, wr, gap;
        logic [31:0] addr, wdata, exp_rd;
        logic [16:0] word;
        int          hold;
    } vec_t;

    typedef struct {
        logic        rdy, we_n, bus, chk_rd;
        logic [17:0] sa;
        logic [15:0] dq;
        logic [31:0] rd;
    } cyc_t;

    cyc_t sb[$];
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_access(input vec_t v);
        int   n = 2 * W + 2;
        cyc_t e;
        for (int k = 0; k < n; k++) begin
            logic hi = k > W;
            e.rdy    = k == n - 1;
            e.bus    = k >= 1 && k <= 2 * W;
            e.we_n   = !(v.wr && e.bus);
            e.sa     = {v.word, hi};
            e.dq     = v.wr ? (hi ? v.wdata[31:16] : v.wdata[15:0]) : (hi ? v.exp_rd[31:16] : v.exp_rd[15:0]);
            e.chk_rd = k == n - 1;
            e.rd     = v.exp_rd;
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mem_read   = k < v.hold ? v.rd : 1'b0;
            mem_write  = k < v.hold ? v.wr : 1'b0;
            address    = k < v.hold ? v.addr : 32'hFFFF_FFFC;
            write_data = k < v.hold ? v.wdata : ~v.wdata;
            #1;
            e = sb.pop_front();
            chk($sformatf("%s c%0d ready", v.name, k), ready, e.rdy);
            chk($sformatf("%s c%0d we_n", v.name, k), SRAM_WE_N, e.we_n);
            if (e.bus) begin
                chk($sformatf("%s c%0d sram_addr", v.name, k), SRAM_ADDR, e.sa);
                chk($sformatf("%s c%0d dq", v.name, k), SRAM_DQ, e.dq);
            end
            if (e.chk_rd) chk($sformatf("%s read_data", v.name), read_data, e.rd);
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"str_1024",  1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 17'h00000, 6};
        vecs[1] = '{"ldr_1032",  1'b1, 1'b0, 1'b1, 32'd1032, 32'h00000000, 32'hABCD1234, 17'h00002, 6};
        vecs[2] = '{"both_1028", 1'b1, 1'b1, 1'b0, 32'd1028, 32'hCAFEF00D, 32'hABCD1234, 17'h00001, 6};
        vecs[3] = '{"ldr_1028",  1'b1, 1'b0, 1'b0, 32'd1028, 32'h00000000, 32'hCAFEF00D, 17'h00001, 6};
        vecs[4] = '{"str_drop",  1'b0, 1'b1, 1'b1, 32'd1036, 32'h55AA0FF0, 32'hCAFEF00D, 17'h00003, 2};
        vecs[5] = '{"ldr_drop",  1'b1, 1'b0, 1'b0, 32'd1036, 32'h00000000, 32'h55AA0FF0, 17'h00003, 1};
        vecs[6] = '{"str_wrap",  1'b0, 1'b1, 1'b0, 32'd1020, 32'h0BADC0DE, 32'h55AA0FF0, 17'h1FFFF, 6};
        vecs[7] = '{"ldr_wrap",  1'b1, 1'b0, 1'b1, 32'd1023, 32'h00000000, 32'h0BADC0DE, 17'h1FFFF, 6};
        vecs[8] = '{"ldr_byte",  1'b1, 1'b0, 1'b0, 32'd1033, 32'h00000000, 32'hABCD1234, 17'h00002, 6};
        clk = 0;
        rst = 1;
        tb_init = 1;
        mem_read = 0;
        mem_write = 0;
        address = 0;
        write_data = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        tb_init = 0;
        #1;
        chk("reset ready", ready, 1'b1);
        chk("reset we_n", SRAM_WE_N, 1'b1);
        chk("reset sram_addr", SRAM_ADDR, 18'h0);
        chk("reset read_data", read_data, 32'h0);
        chk("reset dq", SRAM_DQ, 16'h0000);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].gap) begin
                @(negedge clk);
                #1;
                chk($sformatf("%s idle ready", vecs[i].name), ready, 1'b1);
                chk($sformatf("%s idle we_n", vecs[i].name), SRAM_WE_N, 1'b1);
            end
            do_access(vecs[i]);
        end
        // Reset during the HI half of a store: the low half lands, the high half is abandoned
        @(negedge clk);
        mem_write = 1;
        address = 32'd1024;
        write_data = 32'h11112222;
        #1;
        chk("rst_str accept ready", ready, 1'b0);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            mem_write = 0;
            #1;
            chk($sformatf("rst_str lo c%0d we_n", k), SRAM_WE_N, 1'b0);
        end
        @(negedge clk);
        #1;
        chk("rst_str hi we_n", SRAM_WE_N, 1'b0);
        chk("rst_str hi sram_addr", SRAM_ADDR, 18'h1);
        rst = 1;
        @(negedge clk);
        #1;
        chk("rst_str after ready", ready, 1'b1);
        chk("rst_str after we_n", SRAM_WE_N, 1'b1);
        chk("rst_str after read_data", read_data, 32'h0);
        chk("rst_str after dq", SRAM_DQ, 16'h2222);
        rst = 0;
        do_access('{"ldr_after_rst", 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, 32'hDEAD2222, 17'h0, 6});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
